round_robin_arbiter_n: RTL

Parametrised N-requester round-robin arbiter, the successor to the 2-request arbiter. Grants are combinational from the current requests and a registered rotating priority pointer. The pointer advances past each winner every clock, so access is fair. It sits in front of shared resources: bus ports, memory banks and FIFO read muxes.

---
 rtl/arbiter_pkg.sv | 30 +++
 rtl/fixed_priority_arbiter.sv | 14 +
 rtl/round_robin_arbiter_n.sv | 121 ++++++++++++
 3 files changed

// File: rtl/arbiter_pkg.sv
// Shared helpers for the round-robin arbiter family: wrap-around index increment
// and one-hot to binary encoding, sized generously so any N_REQ instance can use them.
package arbiter_pkg;

    localparam int MAX_REQ = 256;

    // Wrap-around increment by explicit compare so non-power-of-two counts work.
    function automatic int next_idx(input int idx, input int n);
        if (idx == n - 1) begin
            return 0;
        end else begin
            return idx + 1;
        end
    endfunction

    // Binary index of the set bit in a one-hot (or all-zero) vector; zero input gives 0.
    function automatic int onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        int r;
        r = 0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) begin
                r = r | i;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fixed_priority_arbiter.sv
// Lowest-index-wins one-hot arbiter; the building block the round-robin top rotates around.
module fixed_priority_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_req,
    output logic [WIDTH-1:0] o_grant
);

    // Isolate the least significant set bit.
    always_comb begin
        o_grant = i_req & (~i_req + WIDTH'(1'b1));
    end

endmodule

// File: rtl/round_robin_arbiter_n.sv
// N-requester round-robin arbiter with a registered rotating priority pointer.
// Optional transfer locking is enabled by defining ARBITER_LOCK_EN (adds the `last` port).
module round_robin_arbiter_n
    import arbiter_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           requests,
`ifdef ARBITER_LOCK_EN
    input  logic                       last,
`endif
    output logic [N_REQ-1:0]           grants,
    output logic                       grant_valid,
    output logic [$clog2(N_REQ)-1:0]   grant_idx
);

    localparam int IDX_W = $clog2(N_REQ);

    logic [IDX_W-1:0] r_ptr;
    logic [N_REQ-1:0] w_req_rot;
    logic [N_REQ-1:0] w_grant_rot;
    logic [N_REQ-1:0] w_grants_arb;
    logic [N_REQ-1:0] w_grants_sel;
    logic             w_grant_valid;
    logic [IDX_W-1:0] w_winner;

    // Position of rotated bit i in the real request vector, given pointer p.
    function automatic int rot_pos(input int i, input int p);
        return (i + p >= N_REQ) ? (i + p - N_REQ) : (i + p);
    endfunction

    // Rotate requests so the pointer position lands on bit 0.
    always_comb begin
        w_req_rot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_req_rot[i] = requests[rot_pos(i, int'(r_ptr))];
        end
    end

    fixed_priority_arbiter #(
        .WIDTH (N_REQ)
    ) u_fpa (
        .i_req   (w_req_rot),
        .o_grant (w_grant_rot)
    );

    // Undo the rotation on the one-hot result.
    always_comb begin
        w_grants_arb = '0;
        for (int j = 0; j < N_REQ; j++) begin
            w_grants_arb[rot_pos(j, int'(r_ptr))] = w_grant_rot[j];
        end
    end

`ifdef ARBITER_LOCK_EN
    logic             r_locked;
    logic [IDX_W-1:0] r_lock_idx;
    logic             w_lock_hit;

    // A held lock overrides round-robin only while its owner keeps requesting.
    always_comb begin
        w_lock_hit = r_locked & requests[r_lock_idx];
        if (w_lock_hit) begin
            w_grants_sel = {{(N_REQ-1){1'b0}}, 1'b1} << r_lock_idx;
        end else begin
            w_grants_sel = w_grants_arb;
        end
    end

    // Lock on any non-final beat; release on last, on idle, or when the owner drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_locked   <= 1'b0;
            r_lock_idx <= '0;
        end else if (w_grant_valid) begin
            r_locked   <= ~last;
            r_lock_idx <= w_winner;
        end else begin
            r_locked   <= 1'b0;
        end
    end
`else
    // Without locking every grant comes straight from the rotating arbiter.
    always_comb begin
        w_grants_sel = w_grants_arb;
    end
`endif

    // Winner index and validity, before reset gating.
    always_comb begin
        w_grant_valid = |w_grants_sel;
        w_winner      = IDX_W'(onehot_to_idx(MAX_REQ'(w_grants_sel)));
    end

    // Pointer moves just past each winner; idle cycles leave priority untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_grant_valid) begin
            r_ptr <= IDX_W'(next_idx(int'(w_winner), N_REQ));
        end else begin
            r_ptr <= r_ptr;
        end
    end

    // Outputs are combinational but held at zero throughout reset.
    always_comb begin
        if (rst) begin
            grants      = '0;
            grant_valid = 1'b0;
            grant_idx   = '0;
        end else begin
            grants      = w_grants_sel;
            grant_valid = w_grant_valid;
            grant_idx   = w_winner;
        end
    end

endmodule
